// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the 64-bit scoring ALU and its sequencer.
package alu_pkg;

    localparam int ALU_W   = 64;
    localparam int SCORE_W = 10;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_LD_PRI  = 4'h1;
    localparam logic [3:0] OP_LD_SEC  = 4'h2;
    localparam logic [3:0] OP_CNT_CLR = 4'h3;
    localparam logic [3:0] OP_CNT_ACC = 4'h4;
    localparam logic [3:0] OP_CMP_WR  = 4'h5;
    localparam logic [3:0] OP_OUT_XOR = 4'h6;
    localparam logic [3:0] OP_OUT_CNT = 4'h7;

    typedef logic [3:0] seq_state_t;

    localparam seq_state_t S_INIT_LD = 4'd0;
    localparam seq_state_t S_INIT_WR = 4'd1;
    localparam seq_state_t S_CLR     = 4'd2;
    localparam seq_state_t S_LDP     = 4'd3;
    localparam seq_state_t S_LDS     = 4'd4;
    localparam seq_state_t S_XOR     = 4'd5;
    localparam seq_state_t S_LDX     = 4'd6;
    localparam seq_state_t S_CNT     = 4'd7;
    localparam seq_state_t S_RD      = 4'd8;
    localparam seq_state_t S_UPD_LD  = 4'd9;
    localparam seq_state_t S_UPD_WR  = 4'd10;
    localparam seq_state_t S_DONE    = 4'd11;

endpackage

// File: rtl/alu_sequencer.sv
// Micro-sequencer that scores each candidate hash (Hamming distance to its target) on the
// scoring ALU, tracks the best score in the ALU comparator register and reports every result.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int                  WORDS     = 16,
    parameter logic [SCORE_W-1:0]  INIT_BEST = 10'h3FF,
    parameter int                  TAG_W     = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [ALU_W-1:0]    in_hash_i,
    input  logic [ALU_W-1:0]    in_target_i,
    output logic [ALU_W-1:0]    alu_input_o,
    output logic [3:0]          alu_opcode_o,
    input  logic [ALU_W-1:0]    alu_result_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [SCORE_W-1:0]  res_score_o,
    output logic                res_improved_o,
    output logic [TAG_W-1:0]    res_tag_o
);

    localparam int               IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t          state;
    logic [ALU_W-1:0]    target_q;
    logic [ALU_W-1:0]    xor_q;
    logic [SCORE_W-1:0]  score_q;
    logic                improved_q;
    logic [SCORE_W-1:0]  best_q;
    logic [IDX_W-1:0]    idx_q;
    logic [TAG_W-1:0]    tag_q;
    logic [SCORE_W-1:0]  cnt_result;

    assign cnt_result     = alu_result_i[SCORE_W-1:0];
    assign in_ready_o     = (state == S_LDP);
    assign res_valid_o    = (state == S_DONE);
    assign res_score_o    = score_q;
    assign res_improved_o = improved_q;
    assign res_tag_o      = tag_q;

    always_comb begin
        alu_opcode_o = OP_NOP;
        alu_input_o  = '0;
        case (state)
            S_INIT_LD: begin
                alu_opcode_o = OP_LD_SEC;
                alu_input_o  = ALU_W'(INIT_BEST);
            end
            S_INIT_WR: alu_opcode_o = OP_CMP_WR;
            S_CLR:     alu_opcode_o = OP_CNT_CLR;
            S_LDP: begin
                alu_input_o = in_hash_i;
                if (in_valid_i) alu_opcode_o = OP_LD_PRI;
            end
            S_LDS: begin
                alu_opcode_o = OP_LD_SEC;
                alu_input_o  = target_q;
            end
            S_XOR:     alu_opcode_o = OP_OUT_XOR;
            S_LDX: begin
                alu_opcode_o = OP_LD_PRI;
                alu_input_o  = xor_q;
            end
            S_CNT:     alu_opcode_o = OP_CNT_ACC;
            S_RD:      alu_opcode_o = OP_OUT_CNT;
            S_UPD_LD: begin
                alu_opcode_o = OP_LD_SEC;
                alu_input_o  = ALU_W'(score_q);
            end
            S_UPD_WR:  alu_opcode_o = OP_CMP_WR;
            default:   ;
        endcase
        // Keep the ALU idle while reset is held so it never loads during reset.
        if (!rst_ni) begin
            alu_opcode_o = OP_NOP;
            alu_input_o  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_INIT_LD;
            target_q   <= '0;
            xor_q      <= '0;
            score_q    <= '0;
            improved_q <= 1'b0;
            best_q     <= INIT_BEST;
            idx_q      <= '0;
            tag_q      <= '0;
        end else begin
            case (state)
                S_INIT_LD: state <= S_INIT_WR;
                S_INIT_WR: state <= S_CLR;
                S_CLR:     state <= S_LDP;
                S_LDP: begin
                    if (in_valid_i) begin
                        target_q <= in_target_i;
                        state    <= S_LDS;
                    end
                end
                S_LDS:     state <= S_XOR;
                S_XOR: begin
                    xor_q <= alu_result_i;
                    state <= S_LDX;
                end
                S_LDX:     state <= S_CNT;
                S_CNT: begin
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        state <= S_RD;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        state <= S_LDP;
                    end
                end
                S_RD: begin
                    // Ties are not improvements, so the comparator is left untouched.
                    score_q    <= cnt_result;
                    improved_q <= (cnt_result < best_q);
                    state      <= (cnt_result < best_q) ? S_UPD_LD : S_DONE;
                end
                S_UPD_LD:  state <= S_UPD_WR;
                S_UPD_WR: begin
                    best_q <= score_q;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        tag_q <= tag_q + TAG_W'(1);
                        state <= S_CLR;
                    end
                end
                default:   state <= S_INIT_LD;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, directed table, reset-mid-candidate and random candidates.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int WORDS = 16;
    localparam int TAG_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [63:0]       in_hash = '0;
    logic [63:0]       in_target = '0;
    logic [63:0]       alu_input;
    logic [3:0]        alu_opcode;
    logic [63:0]       alu_result;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [9:0]        res_score;
    logic              res_improved;
    logic [TAG_W-1:0]  res_tag;

    alu_sequencer #(.WORDS(WORDS), .INIT_BEST(10'h3FF), .TAG_W(TAG_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_hash_i      (in_hash),
        .in_target_i    (in_target),
        .alu_input_o    (alu_input),
        .alu_opcode_o   (alu_opcode),
        .alu_result_i   (alu_result),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_score_o    (res_score),
        .res_improved_o (res_improved),
        .res_tag_o      (res_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural scoring ALU driven by the sequencer.
    logic [63:0] a_pri, a_sec;
    logic [9:0]  a_cnt, a_cmp;
    always @(posedge clk) begin
        case (alu_opcode)
            OP_LD_PRI:  a_pri <= alu_input;
            OP_LD_SEC:  a_sec <= alu_input;
            OP_CNT_CLR: a_cnt <= '0;
            OP_CNT_ACC: a_cnt <= a_cnt + 10'($countones(a_pri));
            OP_CMP_WR:  a_cmp <= a_sec[9:0];
            default:    ;
        endcase
    end
    always_comb begin
        alu_result = 64'b0;
        if (alu_opcode == OP_OUT_XOR) alu_result = a_pri ^ a_sec;
        if (alu_opcode == OP_OUT_CNT) alu_result = {54'b0, a_cnt};
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Protocol watcher: legal opcodes, NOP while stalled, no input accepted while a result waits.
    int clr_cyc = 0;
    bit after_rd = 0;
    bit upd_seen = 0;
    int n_proto_err = 0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (alu_opcode == OP_CNT_CLR) begin
                clr_cyc  = cyc;
                after_rd = 0;
                upd_seen = 0;
            end
            if (alu_opcode == OP_OUT_CNT) after_rd = 1;
            if (after_rd && (alu_opcode == OP_LD_SEC || alu_opcode == OP_CMP_WR)) upd_seen = 1;
            if (alu_opcode > OP_OUT_CNT) n_proto_err++;
            if (in_ready && res_valid) n_proto_err++;
            if (in_ready && !in_valid && alu_opcode != OP_NOP) n_proto_err++;
            if (res_valid && alu_opcode != OP_NOP) n_proto_err++;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: score is the total differing bit count, truncated to 10 bits.
    logic [63:0] cand_h[WORDS];
    logic [63:0] cand_t[WORDS];
    logic [9:0]  m_best;
    logic [31:0] m_tag;

    task automatic predict(output logic [9:0] sc, output bit imp, output logic [31:0] tg);
        int s = 0;
        for (int w = 0; w < WORDS; w++) s += $countones(cand_h[w] ^ cand_t[w]);
        sc  = 10'(s);
        imp = (sc < m_best);
        if (imp) m_best = sc;
        tg  = m_tag;
        m_tag++;
    endtask

    task automatic send_words(input int n, input int stall_word, input int stall_len);
        bit got;
        for (int w = 0; w < n; w++) begin
            if (w == stall_word) begin
                in_valid = 0;
                repeat (stall_len) @(negedge clk);
            end
            in_valid  = 1;
            in_hash   = cand_h[w];
            in_target = cand_t[w];
            got = 0;
            for (int c = 0; c < 300 && !got; c++) begin
                if (in_ready) begin
                    @(posedge clk);
                    @(negedge clk);
                    got = 1;
                end else begin
                    @(negedge clk);
                end
            end
            if (!got) begin
                n_cmp++;
                n_bad++;
                $display("FAIL word_accept: word %0d not accepted within budget", w);
                in_valid = 0;
                return;
            end
        end
        in_valid = 0;
    endtask

    task automatic wait_result(input string name, input logic [9:0] e_score, input bit e_imp,
                               input logic [31:0] e_tag, input int e_lat, input int hold);
        bit got = 0;
        bit stable;
        int lat;
        logic [42:0] snap;
        for (int c = 0; c < 400 && !got; c++) begin
            if (res_valid) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_valid: no result within budget", name);
            return;
        end
        lat = cyc - clr_cyc;
        check({name, "_score"}, res_score, e_score);
        check({name, "_improved"}, res_improved, e_imp);
        check({name, "_tag"}, res_tag, e_tag);
        check({name, "_cmp_write"}, upd_seen, e_imp);
        check({name, "_best_reg"}, a_cmp, m_best);
        if (e_lat >= 0) check({name, "_latency"}, lat, e_lat);
        if (hold > 0) begin
            snap   = {res_score, res_improved, res_tag};
            stable = 1;
            repeat (hold) begin
                @(negedge clk);
                if ({res_score, res_improved, res_tag} !== snap || !res_valid || in_ready) stable = 0;
            end
            check({name, "_hold_stable"}, stable, 1);
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
    endtask

    task automatic check_init(input int idle);
        bit ok = 1;
        #1;
        check("init_ld", {alu_opcode, alu_input}, {OP_LD_SEC, 64'h3FF});
        @(negedge clk);
        check("init_wr", alu_opcode, OP_CMP_WR);
        @(negedge clk);
        check("init_clr", alu_opcode, OP_CNT_CLR);
        repeat (idle) begin
            @(negedge clk);
            if (alu_opcode != OP_NOP || !in_ready || res_valid) ok = 0;
        end
        check("init_idle", ok, 1);
    endtask

    typedef struct {
        int          x_word;
        logic [63:0] x;
        bit          all_inv;
        int          stall_word;
        int          stall_len;
        int          hold;
        logic [9:0]  e_score;
        bit          e_imp;
        logic [31:0] e_tag;
        int          e_lat;
    } vec_t;

    vec_t rows[6];

    task automatic build_cand(input int x_word, input logic [63:0] x, input bit all_inv);
        for (int w = 0; w < WORDS; w++) begin
            cand_h[w] = {$urandom, $urandom};
            if (all_inv)          cand_t[w] = ~cand_h[w];
            else if (w == x_word) cand_t[w] = cand_h[w] ^ x;
            else                  cand_t[w] = cand_h[w];
        end
    endtask

    initial begin
        logic [9:0]  p_score;
        bit          p_imp;
        logic [31:0] p_tag;
        int          sw;

        rows[0] = '{0,  64'hFF,                  0, -1, 0,  0, 10'd8,  1, 32'd0, -1};
        rows[1] = '{2,  64'hFFF,                 0, -1, 0,  0, 10'd12, 0, 32'd1, 82};
        rows[2] = '{3,  64'hFF00,                0, -1, 0,  0, 10'd8,  0, 32'd2, 82};
        rows[3] = '{15, 64'h8000_0000_0000_0003, 0, -1, 0,  0, 10'd3,  1, 32'd3, 84};
        rows[4] = '{5,  64'h7,                   0, 5,  10, 7, 10'd3,  0, 32'd4, 88};
        rows[5] = '{0,  64'h0,                   1, -1, 0,  0, 10'd0,  1, 32'd5, 84};

        rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {alu_opcode, alu_input, in_ready, res_valid, res_score, res_improved, res_tag},
              {OP_NOP, 64'h0, 1'b0, 1'b0, 10'h0, 1'b0, 32'h0});
        rst_n  = 1;
        m_best = 10'h3FF;
        m_tag  = 0;
        check_init(20);

        foreach (rows[i]) begin
            build_cand(rows[i].x_word, rows[i].x, rows[i].all_inv);
            predict(p_score, p_imp, p_tag);
            send_words(WORDS, rows[i].stall_word, rows[i].stall_len);
            wait_result($sformatf("row%0d", i), rows[i].e_score, rows[i].e_imp,
                        rows[i].e_tag, rows[i].e_lat, rows[i].hold);
        end

        // Reset in the middle of a candidate: partial words dropped, best and tag restart.
        build_cand(0, 64'h3F, 0);
        send_words(10, -1, 0);
        rst_n = 0;
        #1;
        check("midreset_outputs",
              {alu_opcode, alu_input, in_ready, res_valid, res_score, res_improved, res_tag},
              {OP_NOP, 64'h0, 1'b0, 1'b0, 10'h0, 1'b0, 32'h0});
        @(negedge clk);
        rst_n  = 1;
        m_best = 10'h3FF;
        m_tag  = 0;
        check_init(3);
        build_cand(9, 64'h3F0, 0);
        predict(p_score, p_imp, p_tag);
        send_words(WORDS, -1, 0);
        wait_result("after_reset", 10'd6, 1, 32'd0, -1, 0);

        for (int r = 0; r < 12; r++) begin
            for (int w = 0; w < WORDS; w++) begin
                cand_h[w] = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       cand_t[w] = cand_h[w];
                    1:       cand_t[w] = cand_h[w] ^ (64'h1 << $urandom_range(0, 63));
                    2:       cand_t[w] = {$urandom, $urandom};
                    default: cand_t[w] = cand_h[w] ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
                endcase
            end
            predict(p_score, p_imp, p_tag);
            sw = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, WORDS - 1));
            send_words(WORDS, sw, int'($urandom_range(1, 5)));
            wait_result($sformatf("rand%0d", r), p_score, p_imp, p_tag,
                        (sw < 0) ? (p_imp ? 84 : 82) : -1, int'($urandom_range(0, 3)));
        end

        check("protocol_errors", n_proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "time limit");
    end

endmodule
